// File: rtl/adsr_envelope_bank.sv
// Bank of independent linear ADSR envelope generators sharing one set of
// attack/decay/sustain/release parameters. Levels advance only on tick_i.
// Port names carry _i/_o suffixes ("release" alone is a reserved word).

// One envelope channel: state machine plus level register.
module adsr_voice #(
  parameter int LEVEL_WIDTH = 16,
  parameter int STEP_WIDTH  = 8,
  parameter logic [LEVEL_WIDTH-1:0] CEILING = 16'hffff
) (
  input  logic                   clock_i,
  input  logic                   reset_i,
  input  logic                   tick_i,
  input  logic                   note_on_i,
  input  logic                   note_off_i,
  input  logic [STEP_WIDTH-1:0]  step_a_i,
  input  logic [STEP_WIDTH-1:0]  step_d_i,
  input  logic [STEP_WIDTH-1:0]  step_r_i,
  input  logic [LEVEL_WIDTH-1:0] sus_i,
  output logic [LEVEL_WIDTH-1:0] level_o,
  output logic                   active_o
);
  typedef enum logic [2:0] {IDLE, ATTACK, DECAY, SUSTAIN, RELEASE} state_t;
  typedef logic [LEVEL_WIDTH:0] ext_t;

  state_t                 state_q, state_d;
  logic [LEVEL_WIDTH-1:0] level_q, level_d;
  logic                   active_q;

  // One extra bit of headroom so no comparison or sum can wrap.
  ext_t lvl_x, att_sum, dec_thr, step_d_x, step_r_x;
  assign lvl_x    = {1'b0, level_q};
  assign att_sum  = lvl_x + ext_t'(step_a_i);
  assign dec_thr  = {1'b0, sus_i} + ext_t'(step_d_i);
  assign step_d_x = ext_t'(step_d_i);
  assign step_r_x = ext_t'(step_r_i);

  // Next state/level: events update state only and swallow a coincident tick.
  always_comb begin
    state_d = state_q;
    level_d = level_q;
    if (note_on_i) begin
      state_d = ATTACK;
    end else if (note_off_i) begin
      if (state_q inside {ATTACK, DECAY, SUSTAIN}) state_d = RELEASE;
    end else if (tick_i) begin
      case (state_q)
        IDLE: level_d = '0;
        ATTACK: begin
          if (att_sum >= {1'b0, CEILING}) begin
            level_d = CEILING;
            state_d = DECAY;
          end else begin
            level_d = att_sum[LEVEL_WIDTH-1:0];
          end
        end
        DECAY: begin
          if (lvl_x <= dec_thr) begin
            level_d = sus_i;
            state_d = SUSTAIN;
          end else begin
            level_d = level_q - step_d_x[LEVEL_WIDTH-1:0];
          end
        end
        SUSTAIN: level_d = sus_i;
        RELEASE: begin
          if (lvl_x <= step_r_x) begin
            level_d = '0;
            state_d = IDLE;
          end else begin
            level_d = level_q - step_r_x[LEVEL_WIDTH-1:0];
          end
        end
        default: begin
          level_d = '0;
          state_d = IDLE;
        end
      endcase
    end
  end

  // State, level and active flag register together so active tracks state.
  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      state_q  <= IDLE;
      level_q  <= '0;
      active_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      level_q  <= level_d;
      active_q <= (state_d != IDLE);
    end
  end

  assign level_o  = level_q;
  assign active_o = active_q;
endmodule

module adsr_envelope_bank #(
  parameter int VOICES      = 4,
  parameter int LEVEL_WIDTH = 16,
  parameter int PARAM_WIDTH = 7,
  parameter logic [LEVEL_WIDTH-1:0] CEILING = 16'hffff
) (
  input  logic                          clock_i,
  input  logic                          reset_i,
  input  logic                          tick_i,
  input  logic [VOICES-1:0]             note_on_i,
  input  logic [VOICES-1:0]             note_off_i,
  input  logic [PARAM_WIDTH-1:0]        attack_i,
  input  logic [PARAM_WIDTH-1:0]        decay_i,
  input  logic [PARAM_WIDTH-1:0]        sustain_i,
  input  logic [PARAM_WIDTH-1:0]        release_i,
  output logic [VOICES*LEVEL_WIDTH-1:0] level_o,
  output logic [VOICES-1:0]             active_o
);
  localparam int SW = PARAM_WIDTH + 1;
  localparam logic [SW-1:0] FULL = SW'(1) << PARAM_WIDTH;

  // Larger parameter means longer time: step = 2^PARAM_WIDTH - p (128..1).
  logic [SW-1:0]          step_a, step_d, step_r;
  logic [LEVEL_WIDTH-1:0] sus_lvl;
  assign step_a  = FULL - {1'b0, attack_i};
  assign step_d  = FULL - {1'b0, decay_i};
  assign step_r  = FULL - {1'b0, release_i};
  // Bit replication maps 0..127 onto 0..ffff with both endpoints exact.
  assign sus_lvl = {sustain_i, sustain_i, sustain_i[PARAM_WIDTH-1 -: 2]};

  for (genvar v = 0; v < VOICES; v++) begin : g_voice
    adsr_voice #(
      .LEVEL_WIDTH (LEVEL_WIDTH),
      .STEP_WIDTH  (SW),
      .CEILING     (CEILING)
    ) u_voice (
      .clock_i    (clock_i),
      .reset_i    (reset_i),
      .tick_i     (tick_i),
      .note_on_i  (note_on_i[v]),
      .note_off_i (note_off_i[v]),
      .step_a_i   (step_a),
      .step_d_i   (step_d),
      .step_r_i   (step_r),
      .sus_i      (sus_lvl),
      .level_o    (level_o[v*LEVEL_WIDTH +: LEVEL_WIDTH]),
      .active_o   (active_o[v])
    );
  end
endmodule

// File: tb/tb_adsr_envelope_bank.sv
// Directed bench for adsr_envelope_bank with hand-computed expected levels.
module tb_adsr_envelope_bank;
  logic        clock = 1'b0;
  logic        reset, tick;
  logic [3:0]  note_on, note_off, active;
  logic [6:0]  attack, decay, sustain, rel;
  logic [63:0] level;
  int          total = 0, bad = 0;

  always #10 clock = ~clock;

  adsr_envelope_bank dut (
    .clock_i(clock), .reset_i(reset), .tick_i(tick),
    .note_on_i(note_on), .note_off_i(note_off),
    .attack_i(attack), .decay_i(decay), .sustain_i(sustain), .release_i(rel),
    .level_o(level), .active_o(active)
  );

  function automatic logic [15:0] lvl(input int v);
    return level[v*16 +: 16];
  endfunction

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // One clock; outputs are sampled 1 time unit after the edge.
  task automatic cyc();
    @(posedge clock); #1;
  endtask

  task automatic ticks(input int n);
    tick = 1'b1;
    repeat (n) cyc();
    tick = 1'b0;
  endtask

  task automatic ev(input logic [3:0] on, input logic [3:0] off, input logic t);
    note_on = on; note_off = off; tick = t;
    cyc();
    note_on = '0; note_off = '0; tick = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1; cyc(); reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1; tick = 0; note_on = '0; note_off = '0;
    attack = 0; decay = 0; sustain = 64; rel = 0;
    cyc(); cyc();
    reset = 1'b0;
    chk("rst_level", level, 64'h0);
    chk("rst_active", {60'h0, active}, 64'h0);
    ticks(10);
    chk("idle_level", level, 64'h0);
    chk("idle_active", {60'h0, active}, 64'h0);

    // Reset in the middle of an attack.
    ev(4'b0001, 4'b0000, 1'b0);
    ticks(3);
    chk("pre_rst_lvl", {48'h0, lvl(0)}, 64'd384);
    do_reset();
    chk("midrst_lvl", {48'h0, lvl(0)}, 64'h0);
    chk("midrst_act", {60'h0, active}, 64'h0);

    // Fastest attack/decay to sustain 64.
    ev(4'b0001, 4'b0000, 1'b0);
    chk("ev_hold", {48'h0, lvl(0)}, 64'h0);
    chk("ev_act", {60'h0, active}, 64'h1);
    ticks(511);
    chk("att_511", {48'h0, lvl(0)}, 64'd65408);
    ticks(1);
    chk("att_512", {48'h0, lvl(0)}, 64'hffff);
    ticks(253);
    chk("dec_253", {48'h0, lvl(0)}, 64'd33151);
    ticks(2);
    chk("dec_255", {48'h0, lvl(0)}, 64'h8102);
    chk("others_lvl", {16'h0, level[63:16]}, 64'h0);
    chk("others_act", {61'h0, active[3:1]}, 64'h0);

    // Live sustain change, then slowest release.
    sustain = 127;
    ticks(1);
    chk("sus_live", {48'h0, lvl(0)}, 64'hffff);
    rel = 127;
    ev(4'b0000, 4'b0001, 1'b1);
    chk("rel_ev", {48'h0, lvl(0)}, 64'hffff);
    ticks(65534);
    chk("rel_65534", {48'h0, lvl(0)}, 64'd1);
    chk("rel_act", {63'h0, active[0]}, 64'h1);
    ticks(1);
    chk("rel_end_lvl", {48'h0, lvl(0)}, 64'h0);
    chk("rel_end_act", {63'h0, active[0]}, 64'h0);

    // Legato retrigger on voice 2 with the slowest attack.
    attack = 127;
    ev(4'b0100, 4'b0000, 1'b0);
    ticks(1000);
    chk("leg_1000", {48'h0, lvl(2)}, 64'd1000);
    ev(4'b0100, 4'b0000, 1'b1);
    chk("leg_retrig", {48'h0, lvl(2)}, 64'd1000);
    chk("leg_act", {63'h0, active[2]}, 64'h1);
    ticks(5);
    chk("leg_cont", {48'h0, lvl(2)}, 64'd1005);

    // note_on beats note_off; note_off on an idle voice is ignored.
    ev(4'b0010, 4'b0010, 1'b1);
    chk("onoff_act", {63'h0, active[1]}, 64'h1);
    chk("onoff_lvl", {48'h0, lvl(1)}, 64'h0);
    ticks(1);
    chk("onoff_att", {48'h0, lvl(1)}, 64'd1);
    ev(4'b0000, 4'b1000, 1'b0);
    chk("off_idle_act", {63'h0, active[3]}, 64'h0);
    chk("off_idle_lvl", {48'h0, lvl(3)}, 64'h0);

    // Staggered triggers, step 28, saturating into sustain at full scale.
    do_reset();
    attack = 100; decay = 127; sustain = 127;
    ev(4'b0001, 4'b0000, 1'b0);
    ticks(2);
    ev(4'b0010, 4'b0000, 1'b0);
    ticks(3);
    ev(4'b0100, 4'b0000, 1'b1);
    chk("stg_v0_a", {48'h0, lvl(0)}, 64'd168);
    chk("stg_v1_a", {48'h0, lvl(1)}, 64'd112);
    chk("stg_v2_a", {48'h0, lvl(2)}, 64'd0);
    ticks(4);
    chk("stg_v0_b", {48'h0, lvl(0)}, 64'd280);
    chk("stg_v1_b", {48'h0, lvl(1)}, 64'd224);
    chk("stg_v2_b", {48'h0, lvl(2)}, 64'd112);
    chk("stg_v3_b", {48'h0, lvl(3)}, 64'd0);
    ev(4'b1000, 4'b0000, 1'b0);
    ticks(10);
    chk("stg_v0_c", {48'h0, lvl(0)}, 64'd560);
    chk("stg_v1_c", {48'h0, lvl(1)}, 64'd504);
    chk("stg_v2_c", {48'h0, lvl(2)}, 64'd392);
    chk("stg_v3_c", {48'h0, lvl(3)}, 64'd280);
    chk("stg_act", {60'h0, active}, 64'hf);
    ticks(2400);
    chk("stg_sat", level, 64'hffff_ffff_ffff_ffff);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/adsr_envelope_bank.md
Name: adsr_envelope_bank

Overview:
- Bank of VOICES independent linear ADSR envelope generators, advanced by the audio-generation tick (AUDIO_GENERATION_FREQUENCY, 50 kHz enable).
- Sits between the MIDI voice allocator, which supplies note_on/note_off per pipeline voice, and the per-voice amplitude multiplier, which consumes level.
- Generalises the single-voice envelope to N voices with per-voice retrigger and a live-tracking sustain level.
- Attack, decay, sustain and release parameters are shared across all voices.

Parameters:
- VOICES, 4 (PIPELINE_COUNT): number of independent envelope channels.
- LEVEL_WIDTH, 16 (ENVELOPE_COUNTER_WIDTH): envelope level width.
- PARAM_WIDTH, 7 (PERCENT_WIDTH): width of the time and sustain parameters.
- CEILING, 16'hffff (ENVELOPE_CEILING): full-scale level.

Ports:
- clock  in  1  system clock, 50 MHz.
- reset  in  1  synchronous, active-high.
- tick  in  1  one-cycle enable pulse at 50 kHz; levels advance only on tick.
- note_on  in  VOICES  per-voice one-cycle trigger.
- note_off  in  VOICES  per-voice one-cycle release.
- attack  in  PARAM_WIDTH  attack time parameter, 0..127.
- decay  in  PARAM_WIDTH  decay time parameter, 0..127.
- sustain  in  PARAM_WIDTH  sustain level, 0..127.
- release  in  PARAM_WIDTH  release time parameter, 0..127.
- level  out  VOICES*LEVEL_WIDTH  voice v occupies bits [v*16 +: 16]; registered.
- active  out  VOICES  1 when the voice state is not IDLE; registered.

Behaviour:
- Reset: all voices go to IDLE, level=0, active=0. Reset mid-envelope aborts immediately; the first post-reset cycle shows zeros.
- Per-voice states: IDLE, ATTACK, DECAY, SUSTAIN, RELEASE. Voices share no state.
- Step for a time parameter p: step(p) = (PARAM_CEILING+1) - p, computed in 8 bits.
  - p=0 gives step 128 (512 ticks full scale).
  - p=127 gives step 1 (65535 ticks).
- Sustain target S = {sustain, sustain, sustain[6:5]} (bit replication): 127 gives 16'hffff, 0 gives 0, 64 gives 16'h8102.
- Event cycle (note_on or note_off asserted):
  - The state updates on that clock edge.
  - level holds; a coincident tick is consumed with no level change.
- note_on from any state enters ATTACK from the current level (legato retrigger; no reset to 0).
- note_off in ATTACK, DECAY or SUSTAIN enters RELEASE. note_off in IDLE or RELEASE is ignored.
- note_on and note_off in the same cycle on the same voice: note_on wins.
- On tick with no event, level updates by state:
  - IDLE: level=0.
  - ATTACK: sum = level + step(attack) in 17 bits. If sum >= CEILING, level=CEILING and go to DECAY; otherwise level=sum.
  - DECAY: if level <= S + step(decay), level=S and go to SUSTAIN; otherwise level -= step(decay). Compare in 17 bits, no wrap.
  - SUSTAIN: level=S, re-evaluated every tick so a live sustain change takes effect at the next tick. Entering DECAY with level already <= S goes to SUSTAIN at the first tick.
  - RELEASE: if level <= step(release), level=0 and go to IDLE; otherwise level -= step(release).
- active = (state != IDLE), registered with the state. It is deasserted in the same cycle level reaches 0 from RELEASE.
- Latency: level reflects a tick on the clock edge that samples tick (one cycle after tick is asserted).
- No arithmetic wrap under any parameter value. Level is always in 0..CEILING.
- Parameter changes mid-state take effect at the next tick. No latching.

Test Plan:
- Reset, then 10 ticks with no events: level=0 and active=0 on all voices; reset asserted mid-ATTACK returns voice 0 to level 0 and IDLE the next cycle.
- attack=0, decay=0, sustain=64, release=0; note_on[0]:
  - ATTACK reaches 16'hffff exactly at the 512th tick, then DECAY.
  - Level settles at 16'h8102 (SUSTAIN) after 255 decay ticks.
  - Voices 1-3 stay 0 and inactive.
- In SUSTAIN: change sustain 64 to 127, then level=16'hffff at the next tick. Then note_off[0] with release=127: level decrements by 1 per tick; after 65535 ticks level=0 and active=0.
- attack=127 and note_on[2]; after 1000 ticks (level=1000), note_on[2] again: state remains ATTACK, level continues from 1000 with no drop, and the event-cycle tick is consumed (level unchanged that cycle).
- note_on[1] and note_off[1] asserted in the same cycle as tick, from IDLE: voice 1 enters ATTACK and level stays 0 that cycle. note_off[3] with voice 3 in IDLE: no change.
- All four voices triggered on staggered ticks with attack=100 (step 28): each level equals 28 × (ticks elapsed since its trigger, excluding the event cycle), independently, until saturation.
